// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver with valid/ready holding register
//
// Receives LSB-first frames of DATA_WIDTH bits with optional parity and one or two
// stop bits, using 2-of-3 majority sampling around mid-bit. Good words are held in
// P_DATA under a valid/ready handshake; a good word that cannot be stored is dropped
// and flagged as overrun. Break (all-zero frame including first stop) is reported.
//
// Ports:
//   clk           receiver clock (Prescale x baud)
//   rst           asynchronous active-low reset
//   RX_IN         serial line, idle high, asynchronous to clk
//   PAR_EN        parity bit present
//   PAR_TYP       0 = even, 1 = odd parity
//   STOP2         two stop bits expected
//   Prescale      clocks per bit; LSB ignored; values below 8 act as 8
//   data_ready    consumer accepts P_DATA while data_valid is high
//   P_DATA        received word
//   data_valid    P_DATA holds an unconsumed good frame
//   parity_error  1-cycle pulse on parity mismatch
//   framing_error 1-cycle pulse when any stop sample is 0
//   break_det     1-cycle pulse on a break frame
//   overrun       1-cycle pulse when a good word is dropped
//   busy          receiver FSM is not idle
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  break_det,
  output logic                  overrun,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [PRESC_W-1:0] P_MIN       = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] P_EVEN_MASK = {{(PRESC_W-1){1'b1}}, 1'b0};

  logic                  sync1;
  logic                  rx;
  logic [2:0]            state;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [PRESC_W-1:0]    presc_q;
  logic [PRESC_W-1:0]    p_raw;
  logic [PRESC_W-1:0]    p_new;
  logic [PRESC_W-1:0]    half;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic                  s0;
  logic                  s1;
  logic                  par_bit;
  logic                  stop_err;
  logic                  stop_first;
  logic                  stop_cnt;
  logic                  done;
  logic                  wait_high;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_sp;
  logic                  at_end;
  logic                  maj;
  logic                  frame_done;
  logic                  is_break;
  logic                  par_bad;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rx    <= sync1;
    end
  end

  assign p_raw = Prescale & P_EVEN_MASK;
  assign p_new = (p_raw < P_MIN) ? P_MIN : p_raw;
  assign half  = presc_q >> 1;

  assign at_s0  = (edge_cnt == half - PRESC_W'(1));
  assign at_s1  = (edge_cnt == half);
  assign at_sp  = (edge_cnt == half + PRESC_W'(1));
  assign at_end = (edge_cnt == presc_q - PRESC_W'(1));

  // Third sample is the live rx at the sample point.
  assign maj = (s0 & s1) | (s0 & rx) | (s1 & rx);

  assign frame_done = (state == S_STOP) && done;
  assign is_break   = (shreg == '0) && !(par_en_q && par_bit) && !stop_first;
  assign par_bad    = par_en_q && (par_bit != (^shreg ^ par_typ_q));
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      edge_cnt   <= '0;
      presc_q    <= P_MIN;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
      stop_first <= 1'b1;
      stop_cnt   <= 1'b0;
      done       <= 1'b0;
      wait_high  <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        edge_cnt <= at_end ? '0 : edge_cnt + PRESC_W'(1);
        if (at_s0) s0 <= rx;
        if (at_s1) s1 <= rx;
      end
      case (state)
        S_IDLE: begin
          // After a break the line must go high before a new start is armed.
          if (wait_high) begin
            if (rx) wait_high <= 1'b0;
          end else if (!rx) begin
            state     <= S_START;
            edge_cnt  <= '0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
            presc_q   <= p_new;
            bit_cnt   <= '0;
            stop_err  <= 1'b0;
            stop_cnt  <= 1'b0;
            done      <= 1'b0;
          end
        end
        S_START: begin
          if (at_sp && maj) state <= S_IDLE;
          else if (at_end)  state <= S_DATA;
        end
        S_DATA: begin
          if (at_sp) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          if (at_end) begin
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) state <= par_en_q ? S_PARITY : S_STOP;
            else bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        S_PARITY: begin
          if (at_sp)  par_bit <= maj;
          if (at_end) state   <= S_STOP;
        end
        S_STOP: begin
          // Leave half a bit early so the next start edge is caught on time.
          if (done) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            wait_high <= is_break;
          end else begin
            if (at_sp) begin
              if (!maj) stop_err <= 1'b1;
              if (!stop_cnt) stop_first <= maj;
              if (stop_cnt == stop2_q) done <= 1'b1;
            end
            if (at_end) stop_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_DATA        <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_det     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_det     <= 1'b0;
      overrun       <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (frame_done) begin
        if (is_break) begin
          break_det     <= 1'b1;
          framing_error <= 1'b1;
        end else begin
          framing_error <= stop_err;
          parity_error  <= par_bad;
          if (!stop_err && !par_bad) begin
            // A same-cycle consume frees the register for the new word.
            if (!data_valid || data_ready) begin
              P_DATA     <= shreg;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #2.5 clk = ~clk;

  logic       rst_n;
  logic       rx8, rx7, par_en, par_typ, stop2, rdy8, rdy7;
  logic [5:0] presc8, presc7;

  logic [7:0] pd8;
  logic       dv8, pe8o, fe8o, bk8o, ov8o, busy8;
  logic [6:0] pd7;
  logic       dv7, pe7o, fe7o, bk7o, ov7o, busy7;

  uart_rx_cfg #(.DATA_WIDTH(8), .PRESC_W(6)) u8 (
    .clk(clk), .rst(rst_n), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .Prescale(presc8), .data_ready(rdy8), .P_DATA(pd8),
    .data_valid(dv8), .parity_error(pe8o), .framing_error(fe8o),
    .break_det(bk8o), .overrun(ov8o), .busy(busy8)
  );

  uart_rx_cfg #(.DATA_WIDTH(7), .PRESC_W(6)) u7 (
    .clk(clk), .rst(rst_n), .RX_IN(rx7), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .Prescale(presc7), .data_ready(rdy7), .P_DATA(pd7),
    .data_valid(dv7), .parity_error(pe7o), .framing_error(fe7o),
    .break_det(bk7o), .overrun(ov7o), .busy(busy7)
  );

  int n_pe8 = 0, n_fe8 = 0, n_bk8 = 0, n_ov8 = 0, n_xf8 = 0;
  int n_pe7 = 0, n_fe7 = 0, n_bk7 = 0, n_ov7 = 0, n_xf7 = 0;

  always @(negedge clk) begin
    n_pe8 <= n_pe8 + int'(pe8o);
    n_fe8 <= n_fe8 + int'(fe8o);
    n_bk8 <= n_bk8 + int'(bk8o);
    n_ov8 <= n_ov8 + int'(ov8o);
    n_xf8 <= n_xf8 + int'(dv8 && rdy8);
    n_pe7 <= n_pe7 + int'(pe7o);
    n_fe7 <= n_fe7 + int'(fe7o);
    n_bk7 <= n_bk7 + int'(bk7o);
    n_ov7 <= n_ov7 + int'(ov7o);
    n_xf7 <= n_xf7 + int'(dv7 && rdy7);
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_pd8 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rx8 = b;
    else rx7 = b;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nb,
                            input logic pen, input logic typ, input logic pb,
                            input logic s2, input logic st0, input logic st1,
                            input int p, input int gap, input int mid_presc);
    par_en  = pen;
    par_typ = typ;
    stop2   = s2;
    drive(sel, 1'b0);
    wait_cycles(p);
    if (mid_presc > 0) begin
      if (sel == 0) presc8 = 6'(mid_presc);
      else presc7 = 6'(mid_presc);
    end
    for (int i = 0; i < nb; i++) begin
      drive(sel, d[i]);
      wait_cycles(p);
    end
    if (pen) begin
      drive(sel, pb);
      wait_cycles(p);
    end
    drive(sel, st0);
    wait_cycles(p);
    if (s2) begin
      drive(sel, st1);
      wait_cycles(p);
    end
    drive(sel, 1'b1);
    wait_cycles(gap * p);
  endtask

  // Reference outcome of one frame: {good, parity_err, framing_err, break}.
  function automatic logic [3:0] expect_flags(input logic [8:0] d, input int nb,
                                              input logic pen, input logic typ, input logic pb,
                                              input logic s2, input logic st0, input logic st1);
    int ones = 0;
    int allzero = 1;
    logic fe, pe, exp_par;
    for (int i = 0; i < nb; i++) begin
      if (d[i]) begin
        ones++;
        allzero = 0;
      end
    end
    if (allzero == 1 && !(pen && pb) && !st0) return 4'b0011;
    fe = !st0 || (s2 && !st1);
    exp_par = ((ones % 2) == 1) ? ~typ : typ;
    pe = pen && (pb != exp_par);
    return {!fe && !pe, pe, fe, 1'b0};
  endfunction

  task automatic run8(input string tag, input logic [7:0] d, input logic pen, input logic typ,
                      input logic pb, input logic s2, input logic st0, input logic st1);
    int spe, sfe, sbk, sov, sxf;
    logic [3:0] f;
    spe = n_pe8; sfe = n_fe8; sbk = n_bk8; sov = n_ov8; sxf = n_xf8;
    send_frame(0, {1'b0, d}, 8, pen, typ, pb, s2, st0, st1, 8, 2, 0);
    f = expect_flags({1'b0, d}, 8, pen, typ, pb, s2, st0, st1);
    if (f[3]) exp_pd8 = d;
    chk({tag, "/parity_error"},  n_pe8 - spe, {31'd0, f[2]});
    chk({tag, "/framing_error"}, n_fe8 - sfe, {31'd0, f[1]});
    chk({tag, "/break_det"},     n_bk8 - sbk, {31'd0, f[0]});
    chk({tag, "/overrun"},       n_ov8 - sov, 0);
    chk({tag, "/valid_cycles"},  n_xf8 - sxf, {31'd0, f[3]});
    chk({tag, "/P_DATA"},        pd8, exp_pd8);
    chk({tag, "/busy"},          busy8, 0);
    chk({tag, "/data_valid"},    dv8, 0);
  endtask

  initial begin
    int spe, sfe, sbk, sov, sxf;
    logic [7:0] rd;
    logic rpen, rtyp, rpb, rs2, rst0, rst1;

    rst_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    presc8 = 6'd8; presc7 = 6'd16; rdy8 = 1'b1; rdy7 = 1'b1;
    wait_cycles(3);
    chk("reset/P_DATA", pd8, 0);
    chk("reset/data_valid", dv8, 0);
    chk("reset/pulses", {pe8o, fe8o, bk8o, ov8o}, 0);
    chk("reset/busy", busy8, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    run8("t1_8n1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run8("t2_parity", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run8("t3_stop2", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    spe = n_pe8; sfe = n_fe8; sbk = n_bk8; sxf = n_xf8;
    rx8 = 1'b0;
    wait_cycles(2);
    rx8 = 1'b1;
    wait_cycles(24);
    chk("t4_glitch/pulses", (n_pe8 - spe) + (n_fe8 - sfe) + (n_bk8 - sbk) + (n_xf8 - sxf), 0);
    chk("t4_glitch/busy", busy8, 0);
    run8("t4_after", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    spe = n_pe8; sfe = n_fe8; sbk = n_bk8; sxf = n_xf8;
    par_en = 1'b0; stop2 = 1'b0;
    rx8 = 1'b0;
    wait_cycles(11 * 8);
    chk("t5_break/held_idle", busy8, 0);
    wait_cycles(8);
    rx8 = 1'b1;
    wait_cycles(24);
    chk("t5_break/break_det", n_bk8 - sbk, 1);
    chk("t5_break/framing_error", n_fe8 - sfe, 1);
    chk("t5_break/valid_cycles", n_xf8 - sxf, 0);
    chk("t5_break/parity_error", n_pe8 - spe, 0);
    chk("t5_break/P_DATA", pd8, exp_pd8);
    run8("t5_rearm", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 16; k++) begin
      rd   = 8'($urandom);
      rpen = 1'($urandom);
      rtyp = 1'($urandom);
      rs2  = 1'($urandom);
      rpb  = (^rd) ^ rtyp ^ ($urandom_range(0, 3) == 0);
      rst0 = ($urandom_range(0, 4) != 0);
      rst1 = ($urandom_range(0, 4) != 0);
      run8($sformatf("rand%0d", k), rd, rpen, rtyp, rpb, rs2, rst0, rst1);
    end

    rdy8 = 1'b0;
    sov = n_ov8; sxf = n_xf8; sfe = n_fe8;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 0, 0);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 2, 0);
    chk("t6_8/P_DATA", pd8, 8'h11);
    chk("t6_8/data_valid", dv8, 1);
    chk("t6_8/overrun", n_ov8 - sov, 1);
    chk("t6_8/framing_error", n_fe8 - sfe, 0);
    rdy8 = 1'b1;
    wait_cycles(1);
    chk("t6_8/valid_drop", dv8, 0);
    chk("t6_8/transfers", n_xf8 - sxf, 1);

    rx8 = 1'b0;
    wait_cycles(30);
    chk("rst_mid/busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid/busy", busy8, 0);
    chk("rst_mid/P_DATA", pd8, 0);
    chk("rst_mid/data_valid", dv8, 0);
    rx8 = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(4);

    rdy7 = 1'b0;
    presc7 = 6'd16;
    spe = n_pe7; sfe = n_fe7; sbk = n_bk7; sov = n_ov7; sxf = n_xf7;
    send_frame(1, 9'h011, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0, 0);
    send_frame(1, 9'h022, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 2, 8);
    presc7 = 6'd16;
    chk("t6_7/P_DATA", pd7, 7'h11);
    chk("t6_7/data_valid", dv7, 1);
    chk("t6_7/overrun", n_ov7 - sov, 1);
    chk("t6_7/errors", (n_pe7 - spe) + (n_fe7 - sfe) + (n_bk7 - sbk), 0);
    rdy7 = 1'b1;
    wait_cycles(1);
    chk("t6_7/valid_drop", dv7, 0);
    sxf = n_xf7;
    send_frame(1, 9'h05A, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 2, 8);
    presc7 = 6'd16;
    chk("t6_7/P_DATA_mid_presc", pd7, 7'h5A);
    chk("t6_7/transfers", n_xf7 - sxf, 1);
    chk("t6_7/fe_total", n_fe7 - sfe, 0);
    chk("t6_7/busy", busy7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
